// File: rtl/math_op_accum.sv
// Group accumulator for the polynomial math stage: sums N_TERMS accepted beats
// with signed saturation and emits the sum plus an Ising spin decision.
module math_op_accum #(
    parameter int DATA_W  = 32,
    parameter int N_TERMS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_spin,
    output logic              out_sat
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              sticky;

    logic [DATA_W:0]   next_w;
    logic              clamp_hi;
    logic              clamp_lo;
    logic [DATA_W-1:0] clamped;
    logic              accept;
    logic              last_beat;
    logic              spin_next;

    // Valid/ready: a transfer happens on a cycle where valid && ready at the
    // rising edge; a producer holds its payload stable while valid && !ready.
    // The input side may only stall while an unconsumed result is held, since
    // the upstream math pipe has no stall of its own.
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign last_beat = (cnt == LAST_CNT);

    // Overflow of the DATA_W+1 sum shows up as disagreeing top two bits.
    assign next_w   = {acc[DATA_W-1], acc} + {in_data[DATA_W-1], in_data};
    assign clamp_hi = !next_w[DATA_W] && next_w[DATA_W-1];
    assign clamp_lo = next_w[DATA_W] && !next_w[DATA_W-1];

    always_comb begin
        clamped = next_w[DATA_W-1:0];
        if (clamp_hi) begin
            clamped = SAT_MAX;
        end else if (clamp_lo) begin
            clamped = SAT_MIN;
        end
    end

    assign spin_next = ($signed(clamped) >= $signed(threshold));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_spin  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (last_beat) begin
                    // A load here overrides the consume above, keeping out_valid high.
                    out_sum   <= clamped;
                    out_spin  <= spin_next;
                    out_sat   <= sticky || clamp_hi || clamp_lo;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    sticky    <= 1'b0;
                end else begin
                    acc    <= clamped;
                    cnt    <= cnt + CNT_W'(1);
                    sticky <= sticky || clamp_hi || clamp_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_math_op_accum.sv
// Directed bench for math_op_accum: group sums, saturation, backpressure,
// mid-group reset, threshold sampling and full-throughput N_TERMS=1 operation.
module tb_math_op_accum;

    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance with N_TERMS=4
    logic              v4 = 1'b0, rdy4, ov4, or4 = 1'b1, spin4, sat4;
    logic [DATA_W-1:0] d4 = '0, th4 = '0, sum4;
    // Instance with N_TERMS=1
    logic              v1 = 1'b0, rdy1, ov1, or1 = 1'b1, spin1, sat1;
    logic [DATA_W-1:0] d1 = '0, th1 = '0, sum1;

    math_op_accum #(.DATA_W(DATA_W), .N_TERMS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
        .threshold(th4), .out_valid(ov4), .out_ready(or4), .out_sum(sum4),
        .out_spin(spin4), .out_sat(sat4)
    );

    math_op_accum #(.DATA_W(DATA_W), .N_TERMS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .threshold(th1), .out_valid(ov1), .out_ready(or1), .out_sum(sum1),
        .out_spin(spin1), .out_sat(sat1)
    );

    // Scoreboard: expected {sat, spin, sum} per instance
    logic [DATA_W+1:0] exp_q4[$];
    logic [DATA_W+1:0] exp_q1[$];
    logic [DATA_W+1:0] e4, e1;
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [DATA_W+1:0] pk(input logic sat, input logic spin,
                                            input logic [DATA_W-1:0] sum);
        return {sat, spin, sum};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov4 && or4) begin
                n_cmp++;
                if (exp_q4.size() == 0) begin
                    n_err++;
                    $display("FAIL out4 unexpected result sum=%h", sum4);
                end else begin
                    e4 = exp_q4.pop_front();
                    if ({sat4, spin4, sum4} !== e4) begin
                        n_err++;
                        $display("FAIL out4 got sat=%0b spin=%0b sum=%h want sat=%0b spin=%0b sum=%h",
                                 sat4, spin4, sum4, e4[DATA_W+1], e4[DATA_W], e4[DATA_W-1:0]);
                    end
                end
            end
            if (v4) begin
                n_cmp++;
                if (!rdy4) begin
                    n_err++;
                    $display("FAIL drop4 beat offered while in_ready=0 got=0 want=1");
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ov1 && or1) begin
                n_cmp++;
                if (exp_q1.size() == 0) begin
                    n_err++;
                    $display("FAIL out1 unexpected result sum=%h", sum1);
                end else begin
                    e1 = exp_q1.pop_front();
                    if ({sat1, spin1, sum1} !== e1) begin
                        n_err++;
                        $display("FAIL out1 got sat=%0b spin=%0b sum=%h want sat=%0b spin=%0b sum=%h",
                                 sat1, spin1, sum1, e1[DATA_W+1], e1[DATA_W], e1[DATA_W-1:0]);
                    end
                end
            end
        end
    end

    // Drivers: inputs change 1 time unit after the rising edge
    task automatic beat4(input logic [DATA_W-1:0] d);
        v4 = 1'b1;
        d4 = d;
        @(posedge clk);
        #1;
        v4 = 1'b0;
    endtask

    task automatic beat1(input logic [DATA_W-1:0] d);
        v1 = 1'b1;
        d1 = d;
        @(posedge clk);
        #1;
        v1 = 1'b0;
    endtask

    task automatic group4(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
        beat4(a);
        beat4(b);
        beat4(c);
        beat4(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero4(input string tag);
        chk({tag, "_valid"}, {31'd0, ov4}, 32'd0);
        chk({tag, "_sum"}, sum4, 32'd0);
        chk({tag, "_spin"}, {31'd0, spin4}, 32'd0);
        chk({tag, "_sat"}, {31'd0, sat4}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        #1;
        chk_zero4("reset");
        chk("reset_in_ready", {31'd0, rdy4}, 32'd1);
        idle(1);

        // Basic sums against three thresholds
        th4 = 32'd20;
        exp_q4.push_back(pk(1'b0, 1'b1, 32'd24));
        group4(32'd3, 32'd5, 32'd7, 32'd9);
        chk("latency_valid", {31'd0, ov4}, 32'd1);
        idle(1);
        th4 = 32'd24;
        exp_q4.push_back(pk(1'b0, 1'b1, 32'd24));
        group4(32'd3, 32'd5, 32'd7, 32'd9);
        idle(1);
        th4 = 32'd25;
        exp_q4.push_back(pk(1'b0, 1'b0, 32'd24));
        group4(32'd3, 32'd5, 32'd7, 32'd9);
        idle(1);

        // Positive and negative saturation
        th4 = 32'd0;
        exp_q4.push_back(pk(1'b1, 1'b1, 32'h7FFF_FFFA));
        group4(32'h7FFF_FFF0, 32'h0000_0020, 32'hFFFF_FFFB, 32'd0);
        exp_q4.push_back(pk(1'b1, 1'b0, 32'h8000_0000));
        group4(32'h8000_0010, 32'hFFFF_FFE0, 32'd0, 32'd0);
        idle(1);

        // Backpressure: result held for 5 cycles
        or4 = 1'b0;
        exp_q4.push_back(pk(1'b0, 1'b1, 32'd4));
        group4(32'd1, 32'd1, 32'd1, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, ov4}, 32'd1);
            chk("bp_in_ready", {31'd0, rdy4}, 32'd0);
            chk("bp_sum", sum4, 32'd4);
            chk("bp_spin_sat", {30'd0, spin4, sat4}, 32'd2);
        end
        @(posedge clk);
        #1;
        or4 = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, rdy4}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_after_valid", {31'd0, ov4}, 32'd0);
        idle(1);

        // Reset in the middle of a group
        beat4(32'd100);
        beat4(32'd200);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk_zero4("midreset");
        exp_q4.push_back(pk(1'b0, 1'b1, 32'd10));
        group4(32'd1, 32'd2, 32'd3, 32'd4);
        idle(1);

        // Threshold is sampled only on the final beat
        th4 = 32'd50;
        exp_q4.push_back(pk(1'b0, 1'b1, 32'd10));
        beat4(32'd1);
        beat4(32'd2);
        beat4(32'd3);
        th4 = 32'd0;
        beat4(32'd4);
        exp_q4.push_back(pk(1'b0, 1'b0, 32'd10));
        beat4(32'd1);
        beat4(32'd2);
        beat4(32'd3);
        th4 = 32'd50;
        beat4(32'd4);
        idle(1);

        // N_TERMS=1: consume and load in the same cycle
        th1 = 32'd15;
        exp_q1.push_back(pk(1'b0, 1'b0, 32'd10));
        exp_q1.push_back(pk(1'b0, 1'b1, 32'd20));
        exp_q1.push_back(pk(1'b0, 1'b1, 32'd30));
        v1 = 1'b1;
        d1 = 32'd10;
        @(posedge clk);
        #1;
        d1 = 32'd20;
        chk("n1_valid_0", {31'd0, ov1}, 32'd1);
        @(posedge clk);
        #1;
        d1 = 32'd30;
        chk("n1_valid_1", {31'd0, ov1}, 32'd1);
        chk("n1_sum_1", sum1, 32'd20);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        chk("n1_valid_2", {31'd0, ov1}, 32'd1);
        chk("n1_sum_2", sum1, 32'd30);
        @(posedge clk);
        #1;
        chk("n1_valid_end", {31'd0, ov1}, 32'd0);

        idle(4);
        chk("q4_drained", exp_q4.size(), 32'd0);
        chk("q1_drained", exp_q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/math_op_accum.md
Name: math_op_accum

Overview:
- Downstream consumer of the polynomial math stage (d = 3 + c²·(a+b), 2-cycle latency, no valid).
- The issuing controller delays its issue strobe by 2 cycles and presents it as in_valid alongside d.
- This block sums N_TERMS consecutive accepted results with signed saturation and compares the group sum against a threshold to produce an Ising spin decision.
- Each result is delivered on a valid/ready output with a one-deep output register.

Parameters:
- DATA_W, 32, width of in_data, threshold and out_sum (signed two's complement).
- N_TERMS, 8, accepted beats per group; legal range 1..256.

Ports:
- clk  in  1  rising-edge clock, sole clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_W  signed math-stage result d.
- threshold  in  DATA_W  signed spin threshold, sampled on the final beat of a group.
- out_valid  out  1  result registers hold an unconsumed group result.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  DATA_W  saturated signed group sum.
- out_spin  out  1  1 when out_sum >= threshold (signed compare), else 0.
- out_sat  out  1  1 if any clamp occurred during the group.

Behaviour:
- Reset: when rst_n=0 at a clk edge:
  - out_valid, out_sum, out_spin and out_sat become 0.
  - The accumulator, beat counter and sticky sat flag clear.
  - Any partial group is discarded.
  - in_ready is driven 1 in the cycle following reset.
- in_ready is combinational: in_ready = !(out_valid && !out_ready). The 2-cycle math pipe cannot stall, so upstream must not issue when in_ready is deasserted; a beat with in_valid=1 and in_ready=0 is dropped (bench checks no such beat occurs).
- Accept condition: in_valid && in_ready.
- Per accepted beat, the block adds the beat in DATA_W+1 bits:
  - next = acc + in_data.
  - If next > 2^(DATA_W-1)-1, clamp to 0x7FFFFFFF and set sticky sat.
  - If next < -2^(DATA_W-1), clamp to 0x80000000 and set sticky sat.
  - Later beats continue from the clamped value.
- Beat counter runs 0..N_TERMS-1 and increments on each accept.
- Final beat (counter = N_TERMS-1) on the edge:
  - out_sum ← clamped next.
  - out_spin ← (clamped next >= threshold).
  - out_sat ← sticky | clamp on this beat.
  - out_valid ← 1.
  - acc, counter and sticky clear, so the next group starts from 0.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Output handshake: the result is consumed on out_valid && out_ready, and out_valid falls the next cycle unless a new final beat is accepted in the same cycle. In that case the new result loads and out_valid stays 1 (back-to-back, N_TERMS=1 gives full throughput).
- While out_valid && !out_ready: out_* hold stable and in_ready=0.
- Non-final beats never modify out_*.
- N_TERMS=1: every accepted beat is a complete group.
- Two's-complement wrap never occurs; only clamping.

Test Plan:
- N_TERMS=4, threshold=20, beats 3,5,7,9 with out_ready=1 -> one cycle after the 4th beat: out_valid=1, out_sum=24, out_spin=1, out_sat=0. Repeat with threshold=24 -> spin=1; threshold=25 -> spin=0.
- N_TERMS=4, beats 0x7FFFFFF0, 0x20, -5, 0 -> out_sum=0x7FFFFFFA, out_sat=1. Beats 0x80000010, -0x20, 0, 0 -> out_sum=0x80000000, out_sat=1.
- Backpressure:
  - Complete a group (1,1,1,1 -> sum 4) with out_ready=0 held for 5 cycles -> out_valid=1, in_ready=0 and out_* stable for all 5 cycles.
  - Raise out_ready -> in_ready=1 in the same cycle, and out_valid=0 the next cycle.
- N_TERMS=1, continuous beats 10,20,30 with out_ready=1 -> out_sum 10,20,30 on consecutive cycles and out_valid held 1. Confirms simultaneous consume and load.
- Reset mid-group:
  - Accept 2 of 4 beats (100,200), then drop rst_n for one cycle -> all outputs 0.
  - Then beats 1,2,3,4 -> out_sum=10, so no residue from 300.
- Threshold sampling: threshold=50 on beats 1-3, changed to 0 on the final beat, with sum=10 -> out_spin=1. Confirms threshold is sampled on the final beat only.
